// File: rtl/noc_axis_chk_pkg.sv
// -----------------------------------------------------------------------------
// noc_axis_chk_pkg
// Shared definitions for the AXI-Stream frame checker and the traffic
// generator that feeds it:
//   - bit positions inside the 4-bit sticky error code
//   - checker FSM state encoding
//   - backpressure LFSR seed, tap mask and step function
//   - bit offsets of the beat-index and sequence fields inside tdata
// -----------------------------------------------------------------------------
package noc_axis_chk_pkg;

  // Error code bit positions.
  localparam int ERR_DATA = 0;  // payload does not match the pattern
  localparam int ERR_TID  = 1;  // tid changed inside a frame
  localparam int ERR_DEST = 2;  // wrong tdest or partial tkeep
  localparam int ERR_LEN  = 3;  // frame too long, or watchdog timeout

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BODY = 2'd1,
    ST_DONE = 2'd2
  } chk_state_e;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11. In the right-shifting form
  // those taps are state bits 0,2,3,5 and feed back into bit 15.
  localparam logic [15:0] LFSR_SEED     = 16'hACE1;
  localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

  // Pattern field offsets inside tdata.
  localparam int BEAT_IDX_LSB = 0;
  localparam int SEQ_LSB      = 16;

  function automatic logic [15:0] lfsr_step(input logic [15:0] state);
    return {^(state & LFSR_TAP_MASK), state[15:1]};
  endfunction

endpackage

// File: rtl/axis_ready_lfsr.sv
// -----------------------------------------------------------------------------
// axis_ready_lfsr
// 16-bit Fibonacci LFSR used as a pseudo-random handshake throttle
// (tready backpressure here, tvalid throttling in the generator).
// Ports:
//   clk       clock
//   rst_n     asynchronous active-low reset, reloads LFSR_SEED
//   en        advance the LFSR this cycle
//   bit_next  bit 0 of the value the LFSR takes at the next edge, so a
//             caller can register it and stay aligned with the LFSR state
// -----------------------------------------------------------------------------
module axis_ready_lfsr
  import noc_axis_chk_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic bit_next
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = en ? lfsr_step(lfsr_q) : lfsr_q;
  end

  assign bit_next = lfsr_d[0];

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end

endmodule

// File: rtl/axis_frame_checker.sv
// -----------------------------------------------------------------------------
// axis_frame_checker
// AXI-Stream sink that checks every frame against the generator pattern:
// beat k of frame n carries tdata[15:0] = k, tdata[31:16] = n mod 2^16,
// zero above bit 31, tkeep all ones, constant tid, tdest = EXPECTED_TDEST.
// Counts good/bad frames and beats, keeps a sticky error code and raises
// done once the requested number of frames has been closed.
//
// Build option: define AXIS_FRAME_CHECKER_TIMEOUT_EN to add a 16-bit watchdog
// that aborts a frame stalled in BODY (tvalid low) for 16'hFFFF cycles.
//
// Ports:
//   clk_s_axis_i, rst_s_axis_ni      stream clock, async active-low reset
//   s_axis_t*                        AXI-Stream slave (tready generated here)
//   ready_mode_i                     0: always ready, 1: LFSR backpressure
//   expected_frames_i                frames before done (0 = run forever)
//   frames_ok_o/frames_err_o/beats_o saturating statistics
//   err_o, err_code_o                sticky error flag and error bits
//   done_o                           all expected frames closed
// -----------------------------------------------------------------------------
module axis_frame_checker
  import noc_axis_chk_pkg::*;
#(
  parameter int TDATA_WIDTH    = 32,
  parameter int TID_WIDTH      = 5,
  parameter int TDEST_WIDTH    = 5,
  parameter int EXPECTED_TDEST = 0,
  parameter int MAX_FRAME_LEN  = 256,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                     clk_s_axis_i,
  input  logic                     rst_s_axis_ni,
  input  logic                     s_axis_tvalid_i,
  output logic                     s_axis_tready_o,
  input  logic [TDATA_WIDTH-1:0]   s_axis_tdata_i,
  input  logic [TDATA_WIDTH/8-1:0] s_axis_tkeep_i,
  input  logic                     s_axis_tlast_i,
  input  logic [TID_WIDTH-1:0]     s_axis_tid_i,
  input  logic [TDEST_WIDTH-1:0]   s_axis_tdest_i,
  input  logic                     ready_mode_i,
  input  logic [CNT_WIDTH-1:0]     expected_frames_i,
  output logic [CNT_WIDTH-1:0]     frames_ok_o,
  output logic [CNT_WIDTH-1:0]     frames_err_o,
  output logic [CNT_WIDTH-1:0]     beats_o,
  output logic                     err_o,
  output logic [3:0]               err_code_o,
  output logic                     done_o
);

  localparam int IDX_W = (MAX_FRAME_LEN > 1) ? $clog2(MAX_FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0]       IDX_LAST = IDX_W'(MAX_FRAME_LEN - 1);
  localparam logic [TDEST_WIDTH-1:0] TDEST_EXP = TDEST_WIDTH'(EXPECTED_TDEST);

  chk_state_e             state_q;
  logic [IDX_W-1:0]       beat_idx_q;
  logic                   over_q;       // frame already ran past MAX_FRAME_LEN
  logic [3:0]             frame_err_q;  // errors seen so far in this frame
  logic [TID_WIDTH-1:0]   tid_q;
  logic [15:0]            seq_q;
  logic                   tready_q;
  logic [CNT_WIDTH-1:0]   frames_ok_q, frames_err_q, beats_q;
  logic                   err_q;
  logic [3:0]             err_code_q;
  logic                   done_q;

  logic                   lfsr_bit_next;
  logic                   accept;
  logic [IDX_W-1:0]       cur_idx;
  logic                   at_last;
  logic [TDATA_WIDTH-1:0] exp_data;
  logic [3:0]             beat_err;
  logic                   close_any;
  logic [CNT_WIDTH-1:0]   ok_d, err_d;
  logic                   done_cond;
  logic                   stop;
  logic                   tready_d;
  logic                   wd_fire;

  axis_ready_lfsr u_lfsr (
    .clk      (clk_s_axis_i),
    .rst_n    (rst_s_axis_ni),
    .en       (1'b1),
    .bit_next (lfsr_bit_next)
  );

`ifdef AXIS_FRAME_CHECKER_TIMEOUT_EN
  logic [15:0] wd_q;

  assign wd_fire = (state_q == ST_BODY) && !s_axis_tvalid_i && (wd_q == 16'hFFFF);

  always_ff @(posedge clk_s_axis_i or negedge rst_s_axis_ni) begin
    if (!rst_s_axis_ni)                                           wd_q <= '0;
    else if (state_q != ST_BODY || s_axis_tvalid_i || wd_fire)    wd_q <= '0;
    else                                                          wd_q <= wd_q + 16'd1;
  end
`else
  assign wd_fire = 1'b0;
`endif

  // tready is registered and never looks at tvalid, so DONE simply holds it low.
  assign accept  = s_axis_tvalid_i && tready_q;
  assign cur_idx = (state_q == ST_BODY) ? beat_idx_q : '0;
  assign at_last = (cur_idx == IDX_LAST);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    exp_data = '0;
    exp_data[BEAT_IDX_LSB +: 16] = 16'(cur_idx);
    exp_data[SEQ_LSB +: 16]      = seq_q;

    beat_err = '0;
    if (accept) begin
      // Once the index has saturated it no longer tracks the beat number,
      // so the payload check is skipped; the length error already covers it.
      if (!over_q && s_axis_tdata_i != exp_data)              beat_err[ERR_DATA] = 1'b1;
      if (state_q == ST_BODY && s_axis_tid_i != tid_q)        beat_err[ERR_TID]  = 1'b1;
      if (s_axis_tdest_i != TDEST_EXP || s_axis_tkeep_i != '1) beat_err[ERR_DEST] = 1'b1;
      if (!s_axis_tlast_i && at_last)                         beat_err[ERR_LEN]  = 1'b1;
    end
    if (wd_fire) beat_err[ERR_LEN] = 1'b1;

    close_any = (accept && s_axis_tlast_i) || wd_fire;

    ok_d  = frames_ok_q;
    err_d = frames_err_q;
    if (close_any) begin
      if ((frame_err_q | beat_err) != 4'd0) begin
        if (!(&frames_err_q)) err_d = frames_err_q + CNT_WIDTH'(1);
      end else begin
        if (!(&frames_ok_q))  ok_d  = frames_ok_q + CNT_WIDTH'(1);
      end
    end

    done_cond = (expected_frames_i != '0) &&
                (frames_ok_q + frames_err_q == expected_frames_i);

    // Drop tready already on the edge that closes the last frame, so no
    // beat of a following frame slips in before DONE is entered.
    stop = (state_q == ST_DONE) ||
           ((expected_frames_i != '0) && (ok_d + err_d == expected_frames_i));

    tready_d = !stop && (ready_mode_i ? lfsr_bit_next : 1'b1);
  end

  always_ff @(posedge clk_s_axis_i or negedge rst_s_axis_ni) begin
    if (!rst_s_axis_ni) begin
      state_q      <= ST_IDLE;
      beat_idx_q   <= '0;
      over_q       <= 1'b0;
      frame_err_q  <= '0;
      tid_q        <= '0;
      seq_q        <= '0;
      tready_q     <= 1'b0;
      frames_ok_q  <= '0;
      frames_err_q <= '0;
      beats_q      <= '0;
      err_q        <= 1'b0;
      err_code_q   <= '0;
      done_q       <= 1'b0;
    end else begin
      tready_q     <= tready_d;
      frames_ok_q  <= ok_d;
      frames_err_q <= err_d;
      if (accept && !(&beats_q)) beats_q <= beats_q + CNT_WIDTH'(1);
      err_code_q   <= err_code_q | beat_err;
      err_q        <= err_q | (beat_err != 4'd0);
      done_q       <= done_cond;

      case (state_q)
        ST_IDLE, ST_BODY: begin
          if (state_q == ST_IDLE && done_cond) begin
            state_q <= ST_DONE;
          end else if (close_any) begin
            state_q     <= ST_IDLE;
            beat_idx_q  <= '0;
            over_q      <= 1'b0;
            frame_err_q <= '0;
            seq_q       <= seq_q + 16'd1;
          end else if (accept) begin
            if (state_q == ST_IDLE) tid_q <= s_axis_tid_i;
            state_q     <= ST_BODY;
            beat_idx_q  <= at_last ? cur_idx : cur_idx + IDX_W'(1);
            over_q      <= over_q | at_last;
            frame_err_q <= frame_err_q | beat_err;
          end
        end
        default: state_q <= ST_DONE;
      endcase
    end
  end

  assign s_axis_tready_o = tready_q;
  assign frames_ok_o     = frames_ok_q;
  assign frames_err_o    = frames_err_q;
  assign beats_o         = beats_q;
  assign err_o           = err_q;
  assign err_code_o      = err_code_q;
  assign done_o          = done_q;

endmodule
